multi_pulse_stretcher: RTL and testbench
========================================

# multi_pulse_stretcher

- Multi-channel, parametrised pulse stretcher.
- Converts rising edges on up to NUM_CH independent trigger inputs into output pulses of run-time-programmable length.
- Adds a post-pulse holdoff window, a per-pulse done strobe and an optional retrigger mode.
- Sits between debounced/synchronised event sources (buttons, sensor strobes, one-cycle control pulses) and slow consumers (LEDs, audio/PWM gates, display logic) that need a wide, well-defined enable.

## Interface
- NUM_CH, 4: number of independent channels (>=1)
- CNT_W, 16: width of length counter; max pulse length 2^CNT_W-1 cycles
- HOLDOFF, 0: cycles after each pulse during which triggers are ignored; must be < 2^CNT_W
- clk  input  1  system clock, all logic rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  global trigger accept enable
- abort  input  1  synchronous clear of all channels
- len  input  CNT_W  pulse length in cycles, sampled per channel at trigger acceptance
- trig_in  input  NUM_CH  trigger inputs; must already be synchronous to clk
- pulse_out  output  NUM_CH  stretched pulses, registered
- done_out  output  NUM_CH  one-cycle strobe at end of each completed pulse, registered
- busy  output  1  OR of all channels not IDLE (combinational from state regs)

## Operation
- Per-channel edge detect: trig_prev register; edge = trig_in & ~trig_prev. trig_prev resets to 0, so an input held high through reset release produces one edge.
- Per-channel states: IDLE, ACTIVE, HOLD. Down-counter cnt[CNT_W-1:0].
- IDLE: if edge && en && len!=0 -> ACTIVE, cnt<=len-1. len==0 -> trigger ignored, no pulse, no done.
- ACTIVE: pulse_out=1.
  - cnt!=0 -> cnt--.
  - cnt==0 -> done_out strobe next cycle. Go HOLD with cnt<=HOLDOFF-1 if HOLDOFF>0, else IDLE.
- HOLD: all edges ignored and lost. cnt!=0 -> cnt--; cnt==0 -> IDLE.
- HOLDOFF=0, edge on the same edge ACTIVE expires: new pulse starts; pulse_out stays high (back-to-back), done_out still strobes once for the first pulse.
- en low: no new acceptance; pulses in ACTIVE/HOLD run to completion.
- abort (priority over everything): all channels -> IDLE, cnt<=0, pulse_out<=0, no done_out. trig_prev still updates, so a high input does not re-fire after abort.
- len changes mid-pulse: no effect on running pulses.
- Channels fully independent; simultaneous triggers on any subset all accepted.

## Timing
- Reset values: pulse_out=0, done_out=0, busy=0, all channels IDLE, cnt=0, trig_prev=0.
- Latency: trig_in rises before edge k -> pulse_out high from edge k for exactly len cycles, low from edge k+len.
- done_out high for the single cycle starting at edge k+len.
- Earliest next accepted trigger edge: k+len+HOLDOFF.
- Reset assertion mid-pulse: outputs clear immediately (async). Release is synchronous by construction of the upstream reset synchroniser.

## Configuration
- PULSE_STRETCH_RETRIG_EN defined:
  - edge && en in ACTIVE reloads cnt<=len-1 (len!=0), extending the pulse to len cycles from the retrigger.
  - No done_out for the extended portion; one done_out at final end.
  - Triggers in HOLD still ignored.
- Not defined: edges in ACTIVE ignored; pulse length fixed at first acceptance.

## Structure
- Package pulse_stretch_pkg: state enum (IDLE, ACTIVE, HOLD), state width constant, compile-time check that HOLDOFF < 2^CNT_W.
- Sub-module pulse_stretch_ch: one channel (edge detect, FSM, counter, registered outputs).
- Top generates NUM_CH instances and ORs busy.

## Test plan
- Basic: len=5, HOLDOFF=0, one-cycle pulse on ch0 -> pulse_out[0] high exactly 5 cycles, done_out[0] one cycle at cycle 6, busy tracks, other channels stay 0.
- Holdoff: len=3, HOLDOFF=4, second edge 5 cycles after first -> ignored; edge at 7 cycles -> accepted, 3-cycle pulse.
- Retrigger:
  - len=8, second edge at cycle 4.
  - Macro on -> pulse 12 cycles, one done.
  - Macro off -> pulse 8 cycles, second edge lost.
- Edge cases:
  - len=0 -> no pulse/done.
  - en=0 during edge -> no pulse.
  - en dropped mid-pulse -> pulse completes.
  - Trigger held high across rst_n release -> exactly one pulse.
- Abort and reset:
  - abort at cycle 2 of len=10 -> pulse_out 0 next cycle, no done_out.
  - rst_n low mid-pulse -> outputs 0 immediately.
- Concurrency: NUM_CH=4, all channels triggered same cycle with len=6, plus HOLDOFF=0 back-to-back edge on ch2 at expiry -> all pulses 6 cycles; ch2 continuous 12 cycles with one done_out at cycle 7.

Source files
------------

// File: rtl/multi_pulse_stretcher_pkg.sv
// Shared types and elaboration helpers for the multi-channel pulse stretcher.
// Optional retrigger behaviour is selected with the PULSE_STRETCH_RETRIG_EN macro.
package pulse_stretch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } ps_state_t;

  function automatic bit holdoff_fits(longint unsigned holdoff, int unsigned cnt_w);
    if (cnt_w >= 63) return 1'b1;
    return holdoff < (64'd1 << cnt_w);
  endfunction

endpackage

// File: rtl/multi_pulse_stretcher_if.sv
// Control, trigger and pulse bundle between an event source and the stretcher.
// The master side drives triggers and configuration; the slave side returns the pulses.
interface multi_pulse_stretcher_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) ();

  logic              en;
  logic              abort;
  logic [CNT_W-1:0]  len;
  logic [NUM_CH-1:0] trig_in;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] done_out;
  logic              busy;

  modport master (
    output en, abort, len, trig_in,
    input  pulse_out, done_out, busy
  );

  modport slave (
    input  en, abort, len, trig_in,
    output pulse_out, done_out, busy
  );

endinterface

// File: rtl/multi_pulse_stretcher_ch.sv
// One stretcher channel: rising-edge detect, IDLE/ACTIVE/HOLD sequencer and length counter.
// Defining PULSE_STRETCH_RETRIG_EN lets a new edge during ACTIVE extend the running pulse.
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int          CNT_W   = 16,
  parameter int unsigned HOLDOFF = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  input  logic             trig_in,
  output logic             pulse_out,
  output logic             done_out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  ps_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             trig_prev;
  logic             start;

  assign start = trig_in && !trig_prev && en && (len != '0);
  assign busy  = (state != IDLE);

  // The last HOLD cycle also evaluates triggers, so the next acceptance lands exactly HOLDOFF cycles after the pulse ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      trig_prev <= 1'b0;
      pulse_out <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      trig_prev <= trig_in;
      done_out  <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cnt       <= '0;
        pulse_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= ACTIVE;
              cnt       <= len - 1'b1;
              pulse_out <= 1'b1;
            end
          end
          ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIG_EN
            if (start) begin
              cnt <= len - 1'b1;
            end else
`endif
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              done_out <= 1'b1;
              if (HOLDOFF == 0 && start) begin
                cnt <= len - 1'b1;
              end else if (HOLDOFF > 0) begin
                state     <= HOLD;
                cnt       <= HOLD_LOAD;
                pulse_out <= 1'b0;
              end else begin
                state     <= IDLE;
                pulse_out <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (start) begin
              state     <= ACTIVE;
              cnt       <= len - 1'b1;
              pulse_out <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_pulse_stretcher.sv
// Top level: NUM_CH independent pulse_stretch_ch channels sharing en/abort/len.
// Retrigger support is compiled in when PULSE_STRETCH_RETRIG_EN is defined.
module multi_pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 16,
  parameter int unsigned HOLDOFF = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  multi_pulse_stretcher_if.slave bus
);

  logic [NUM_CH-1:0] pulse_vec;
  logic [NUM_CH-1:0] done_vec;
  logic [NUM_CH-1:0] busy_vec;

  if (!holdoff_fits(longint'(HOLDOFF), CNT_W)) begin : g_bad_holdoff
    $error("HOLDOFF must be smaller than 2**CNT_W");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_stretch_ch #(
      .CNT_W   (CNT_W),
      .HOLDOFF (HOLDOFF)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bus.en),
      .abort     (bus.abort),
      .len       (bus.len),
      .trig_in   (bus.trig_in[i]),
      .pulse_out (pulse_vec[i]),
      .done_out  (done_vec[i]),
      .busy      (busy_vec[i])
    );
  end

  assign bus.pulse_out = pulse_vec;
  assign bus.done_out  = done_vec;
  assign bus.busy      = |busy_vec;

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Drives two stretchers (HOLDOFF 0 and 4) with directed and random triggers against a timestamp model.
// The model honours PULSE_STRETCH_RETRIG_EN the same way the build does.
module tb_multi_pulse_stretcher;

  localparam int NCH   = 4;
  localparam int CW    = 16;
  localparam int HO [2] = '{0, 4};
`ifdef PULSE_STRETCH_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk;
  logic rst_n;

  multi_pulse_stretcher_if #(.NUM_CH(NCH), .CNT_W(CW)) bus0 ();
  multi_pulse_stretcher_if #(.NUM_CH(NCH), .CNT_W(CW)) bus4 ();

  multi_pulse_stretcher #(.NUM_CH(NCH), .CNT_W(CW), .HOLDOFF(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  multi_pulse_stretcher #(.NUM_CH(NCH), .CNT_W(CW), .HOLDOFF(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic          s_en;
  logic          s_abort;
  logic [CW-1:0] s_len;
  logic [NCH-1:0] s_trig;

  // Model state: a pulse is described by the cycle it ends and the earliest cycle a new one may start.
  bit m_prev   [2][NCH];
  bit m_run    [2][NCH];
  int m_end    [2][NCH];
  int m_accept [2][NCH];
  logic [NCH-1:0] e_pulse [2];
  logic [NCH-1:0] e_done  [2];
  logic           e_busy  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b expected %b", tag, k, observed, expected);
    end
  endtask

  task automatic setInputs(input logic en_v, input logic abort_v, input logic [CW-1:0] len_v,
                           input logic [NCH-1:0] trig_v);
    s_en = en_v; s_abort = abort_v; s_len = len_v; s_trig = trig_v;
    bus0.en = en_v; bus0.abort = abort_v; bus0.len = len_v; bus0.trig_in = trig_v;
    bus4.en = en_v; bus4.abort = abort_v; bus4.len = len_v; bus4.trig_in = trig_v;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        m_prev[d][c] = 1'b0; m_run[d][c] = 1'b0; m_end[d][c] = 0; m_accept[d][c] = 0;
      end
      e_pulse[d] = '0; e_done[d] = '0; e_busy[d] = 1'b0;
    end
  endtask

  task automatic modelStep();
    bit edge_seen, start;
    k++;
    for (int d = 0; d < 2; d++) begin
      e_busy[d] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        edge_seen = s_trig[c] && !m_prev[d][c];
        m_prev[d][c] = s_trig[c];
        start = edge_seen && s_en && (s_len != 0);
        e_done[d][c] = 1'b0;
        if (s_abort) begin
          m_run[d][c] = 1'b0;
          m_accept[d][c] = k;
        end else if (RETRIG && m_run[d][c] && start) begin
          m_end[d][c] = k + int'(s_len);
          m_accept[d][c] = m_end[d][c] + HO[d];
        end else begin
          if (m_run[d][c] && k == m_end[d][c]) begin
            e_done[d][c] = 1'b1;
            m_run[d][c] = 1'b0;
          end
          if (!m_run[d][c] && start && k >= m_accept[d][c]) begin
            m_run[d][c] = 1'b1;
            m_end[d][c] = k + int'(s_len);
            m_accept[d][c] = m_end[d][c] + HO[d];
          end
        end
        e_pulse[d][c] = m_run[d][c];
        if (m_run[d][c] || k < m_accept[d][c]) e_busy[d] = 1'b1;
      end
    end
  endtask

  // One clock: inputs settle, the edge happens, then both DUTs are compared with the model.
  task automatic applyStimulus(input logic en_v, input logic abort_v, input logic [CW-1:0] len_v,
                               input logic [NCH-1:0] trig_v);
    setInputs(en_v, abort_v, len_v, trig_v);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("h0_pulse", bus0.pulse_out, e_pulse[0]);
    checkOutput("h0_done",  bus0.done_out,  e_done[0]);
    checkOutput("h0_busy",  {3'b000, bus0.busy}, {3'b000, e_busy[0]});
    checkOutput("h4_pulse", bus4.pulse_out, e_pulse[1]);
    checkOutput("h4_done",  bus4.done_out,  e_done[1]);
    checkOutput("h4_busy",  {3'b000, bus4.busy}, {3'b000, e_busy[1]});
  endtask

  task automatic idleCycles(input int n, input logic [CW-1:0] len_v);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, len_v, '0);
  endtask

  task automatic doReset(input logic [NCH-1:0] trig_v);
    rst_n = 1'b0;
    setInputs(1'b1, 1'b0, 16'd5, trig_v);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pulse", bus0.pulse_out | bus4.pulse_out, 4'b0000);
    checkOutput("rst_done",  bus0.done_out | bus4.done_out, 4'b0000);
    checkOutput("rst_busy",  {2'b00, bus0.busy, bus4.busy}, 4'b0000);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0] trig_r;
    logic [CW-1:0]  len_r;
    $display("[TB] start, retrigger build = %0d", RETRIG);

    // Trigger on ch1 held high across reset release: exactly one pulse.
    doReset(4'b0010);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'd5, 4'b0010);
    idleCycles(6, 16'd5);

    // Basic five-cycle pulse on ch0.
    applyStimulus(1'b1, 1'b0, 16'd5, 4'b0001);
    idleCycles(12, 16'd5);

    // Holdoff window: edges 5 and 7 cycles after the first, len=3.
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b1, 1'b0, 16'd3, (i == 0 || i == 5 || i == 7) ? 4'b0001 : 4'b0000);
    idleCycles(8, 16'd3);

    // Retrigger case: len=8, second edge four cycles in.
    for (int i = 0; i < 22; i++)
      applyStimulus(1'b1, 1'b0, 16'd8, (i == 0 || i == 4) ? 4'b0001 : 4'b0000);

    // len=0 and en=0 triggers are ignored.
    applyStimulus(1'b1, 1'b0, 16'd0, 4'b1111);
    idleCycles(4, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'd4, 4'b1111);
    idleCycles(4, 16'd4);

    // en dropped mid-pulse; len changes mid-pulse have no effect.
    applyStimulus(1'b1, 1'b0, 16'd6, 4'b0100);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 16'd2, 4'b0000);
    idleCycles(6, 16'd2);

    // Abort on the second cycle of a len=10 pulse, with trigger kept high.
    applyStimulus(1'b1, 1'b0, 16'd10, 4'b1000);
    applyStimulus(1'b1, 1'b0, 16'd10, 4'b1000);
    applyStimulus(1'b1, 1'b1, 16'd10, 4'b1000);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 16'd10, 4'b1000);
    idleCycles(6, 16'd10);

    // All channels at once, plus ch2 re-fired exactly at expiry.
    for (int i = 0; i < 24; i++)
      applyStimulus(1'b1, 1'b0, 16'd6, (i == 0) ? 4'b1111 : ((i == 6) ? 4'b0100 : 4'b0000));

    // Asynchronous reset in the middle of a pulse clears outputs before the next edge.
    applyStimulus(1'b1, 1'b0, 16'd10, 4'b0011);
    idleCycles(3, 16'd10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pulse", bus0.pulse_out | bus4.pulse_out, 4'b0000);
    checkOutput("async_rst_busy",  {2'b00, bus0.busy, bus4.busy}, 4'b0000);
    @(posedge clk);
    doReset(4'b0000);

    // Random traffic.
    trig_r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) trig_r[c] = ~trig_r[c];
      len_r = CW'($urandom_range(0, 9));
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 60) == 0, len_r, trig_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
